// File: rtl/i8008_pkg.sv
// Shared core package: command encoding, bus cycle types, address width
// default, and the restart-vector helper used by the address stack.
package i8008_pkg;

  localparam int ADDR_WIDTH_DEF = 14;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_INC   = 3'd1,
    OP_LD_LO = 3'd2,
    OP_LD_HI = 3'd3,
    OP_JMP   = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6,
    OP_RST   = 3'd7
  } stack_op_t;

  // Bus cycle type carried on the top two bits of the high address byte.
  typedef enum logic [1:0] {
    CYC_PCI = 2'b00,
    CYC_PCR = 2'b10,
    CYC_PCC = 2'b01,
    CYC_PCW = 2'b11
  } cyc_type_t;

  // Restart target: eight-byte aligned vector selected by d_in[5:3].
  function automatic logic [13:0] rst_vector(input logic [7:0] d);
    return {8'b0, d[5:3], 3'b000};
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Address stack storage: DEPTH entries of ADDR_WIDTH bits, one synchronous
// write port and one asynchronous read port. All entries clear on reset.
module stack_mem #(
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 8,
  parameter int SP_WIDTH   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [SP_WIDTH-1:0]   waddr,
  input  logic [ADDR_WIDTH-1:0] wdata,
  input  logic [SP_WIDTH-1:0]   raddr,
  output logic [ADDR_WIDTH-1:0] rdata
);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];

  // Entry write; reset clears every entry and overrides a pending write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/addr_stack_ctrl.sv
// Program-address stack controller: op decode, stack pointer, jump-target
// holding register and optional depth/overflow/underflow checking.
// Optional feature macro: ADDR_STACK_CHECK_EN compiles in the depth counter
// and sticky ovf/unf flags; without it the flags are tied low.
module addr_stack_ctrl
  import i8008_pkg::*;
#(
  parameter int  ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int  DEPTH      = 8,
  localparam int SP_WIDTH   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  stack_op_t             op,
  input  logic [7:0]            d_in,
  input  logic [1:0]            cyc_type,
  input  logic                  clr_flags,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [7:0]            addr_lo,
  output logic [7:0]            addr_hi,
  output logic [SP_WIDTH-1:0]   sp,
  output logic                  ovf,
  output logic                  unf
);

  logic [ADDR_WIDTH-1:0] tmp;
  logic [ADDR_WIDTH-1:0] tmp_nxt;
  logic [SP_WIDTH-1:0]   sp_nxt;
  logic                  mem_we;
  logic [SP_WIDTH-1:0]   mem_waddr;
  logic [ADDR_WIDTH-1:0] mem_wdata;
  logic                  push;
  logic                  pop;
  logic [13:0]           pc14;

  stack_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH),
    .SP_WIDTH  (SP_WIDTH)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .raddr(sp),
    .rdata(pc)
  );

  // Op decode: pick the stack write, next sp and next tmp for this cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = sp;
    mem_wdata = pc;
    sp_nxt    = sp;
    tmp_nxt   = tmp;
    push      = 1'b0;
    pop       = 1'b0;
    case (op)
      OP_INC: begin
        mem_we    = 1'b1;
        mem_wdata = pc + ADDR_WIDTH'(1);
      end
      OP_LD_LO: tmp_nxt[7:0] = d_in;
      OP_LD_HI: tmp_nxt[13:8] = d_in[5:0];
      OP_JMP: begin
        mem_we    = 1'b1;
        mem_wdata = tmp;
      end
      OP_CALL: begin
        sp_nxt    = sp + SP_WIDTH'(1);
        mem_we    = 1'b1;
        mem_waddr = sp + SP_WIDTH'(1);
        mem_wdata = tmp;
        push      = 1'b1;
      end
      OP_RST: begin
        sp_nxt    = sp + SP_WIDTH'(1);
        mem_we    = 1'b1;
        mem_waddr = sp + SP_WIDTH'(1);
        mem_wdata = ADDR_WIDTH'(rst_vector(d_in));
        push      = 1'b1;
      end
      OP_RET: begin
        sp_nxt = sp - SP_WIDTH'(1);
        pop    = 1'b1;
      end
      default: ;
    endcase
  end

  // Stack pointer and jump-target register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp  <= '0;
      tmp <= '0;
    end else begin
      sp  <= sp_nxt;
      tmp <= tmp_nxt;
    end
  end

`ifdef ADDR_STACK_CHECK_EN
  localparam logic [SP_WIDTH-1:0] DEPTH_MAX = SP_WIDTH'(DEPTH - 1);

  logic [SP_WIDTH-1:0] depth;

  // Depth tracking saturates at both ends while sp keeps wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      depth <= '0;
    end else if (push && depth != DEPTH_MAX) begin
      depth <= depth + SP_WIDTH'(1);
    end else if (pop && depth != '0) begin
      depth <= depth - SP_WIDTH'(1);
    end
  end

  // Sticky error flags; a same-cycle set takes priority over clr_flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (push && depth == DEPTH_MAX) ovf <= 1'b1;
      else if (clr_flags)             ovf <= 1'b0;
      if (pop && depth == '0)         unf <= 1'b1;
      else if (clr_flags)             unf <= 1'b0;
    end
  end
`else
  logic unused_chk;
  assign unused_chk = &{1'b0, clr_flags, push, pop};
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

  assign pc14    = 14'(pc);
  assign addr_lo = pc14[7:0];
  assign addr_hi = {cyc_type, pc14[13:8]};

endmodule
